zx_ram_arbiter: RTL

Time-multiplexes the single-port 64 KB ZX Spectrum main RAM (dual SPRAM bank, 1-cycle registered read) between the Z80 CPU and the video fetch unit. The CPU port uses a req/ack handshake; the video port is a pipelined read stream with same-cycle grant. The video port has fixed priority, and a run-length guard bounds how long the CPU can wait. It sits between the CPU bus glue / video fetcher and the RAM wrapper, and shares that wrapper's clock.

---
 rtl/zx_ram_arb_pkg.sv | 16 +
 rtl/zx_ram_arbiter_if.sv | 40 ++++
 rtl/zx_ram_resp_pipe.sv | 44 ++++
 rtl/zx_ram_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/zx_ram_arb_pkg.sv
// Shared types and constants for the ZX Spectrum main-RAM arbiter.
package zx_ram_arb_pkg;

    localparam int RAM_AW            = 16;
    localparam int RAM_DW            = 8;
    localparam int MAX_VIDEO_RUN_DEF = 4;

    // Who owns the RAM access travelling through the response pipeline.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_CPU_WR = 2'd2,
        OWN_VID    = 2'd3
    } owner_e;

endpackage

// File: rtl/zx_ram_arbiter_if.sv
// Client-side bus of the RAM arbiter: CPU req/ack port and video read stream.
//
// Handshakes:
//   CPU   - the CPU raises cpu_req with cpu_we/cpu_addr/cpu_wdata and holds them
//           stable until cpu_ack. cpu_ack is a one-cycle completion pulse; in that
//           cycle the CPU either drops cpu_req or keeps it up for a new access,
//           which is only looked at from the following cycle onward.
//   Video - vid_req/vid_addr form a request that is accepted in any cycle where
//           vid_gnt is high (same-cycle, combinational grant). Every accepted
//           read returns exactly one vid_valid pulse two cycles later, in grant
//           order. There is no backpressure on vid_valid.
interface zx_ram_arbiter_if;
    import zx_ram_arb_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [RAM_AW-1:0] cpu_addr;
    logic [RAM_DW-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [RAM_DW-1:0] cpu_rdata;

    logic              vid_req;
    logic [RAM_AW-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_valid;
    logic [RAM_DW-1:0] vid_data;

    // Clients (CPU glue and video fetcher) drive requests.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
        input  cpu_ack, cpu_rdata, vid_gnt, vid_valid, vid_data
    );

    // The arbiter answers them.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
        output cpu_ack, cpu_rdata, vid_gnt, vid_valid, vid_data
    );

endinterface

// File: rtl/zx_ram_resp_pipe.sv
// Two-stage owner tag / data shift register that turns RAM read data into
// cpu_ack/cpu_rdata or vid_valid/vid_data two cycles after the grant.
module zx_ram_resp_pipe
    import zx_ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  owner_e            owner_i,
    input  logic [RAM_DW-1:0] ram_dout_i,
    output logic              cpu_ack_o,
    output logic [RAM_DW-1:0] cpu_rdata_o,
    output logic              vid_valid_o,
    output logic [RAM_DW-1:0] vid_data_o
);

    owner_e            stage1_q;
    owner_e            stage2_q;
    logic [RAM_DW-1:0] data_q;
    logic [RAM_DW-1:0] cpu_rdata_q;

    // Shift tags one stage per cycle; RAM data is valid while stage 1 is occupied.
    // cpu_rdata_q only loads for CPU reads so it holds between acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q    <= OWN_NONE;
            stage2_q    <= OWN_NONE;
            data_q      <= '0;
            cpu_rdata_q <= '0;
        end else begin
            stage1_q <= owner_i;
            stage2_q <= stage1_q;
            data_q   <= ram_dout_i;
            if (stage1_q == OWN_CPU_RD) begin
                cpu_rdata_q <= ram_dout_i;
            end
        end
    end

    assign cpu_ack_o   = (stage2_q == OWN_CPU_RD) || (stage2_q == OWN_CPU_WR);
    assign cpu_rdata_o = cpu_rdata_q;
    assign vid_valid_o = (stage2_q == OWN_VID);
    assign vid_data_o  = data_q;

endmodule

// File: rtl/zx_ram_arbiter.sv
// ZX Spectrum main-RAM arbiter: video has fixed priority, a run-length guard
// bounds how long a waiting CPU access can be held off.
module zx_ram_arbiter
    import zx_ram_arb_pkg::*;
#(
    parameter int MAX_VIDEO_RUN = MAX_VIDEO_RUN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    zx_ram_arbiter_if.slave   bus,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_din,
    input  logic [RAM_DW-1:0] ram_dout
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_VIDEO_RUN);

    logic   cpu_busy_q, cpu_busy_d;
    logic   [3:0] vid_run_q, vid_run_d;
    logic   cpu_ok;
    logic   vid_grant;
    logic   cpu_grant;
    owner_e owner;
    logic   pipe_cpu_ack;
    logic   pipe_vid_valid;

    // Issue decision: video wins unless it has used up its run while the CPU waits.
    always_comb begin
        cpu_ok    = bus.cpu_req & ~cpu_busy_q;
        vid_grant = bus.vid_req & (~cpu_ok | (vid_run_q < RUN_MAX));
        cpu_grant = cpu_ok & ~vid_grant;

        owner = OWN_NONE;
        if (vid_grant) begin
            owner = OWN_VID;
        end else if (cpu_grant) begin
            owner = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
        end

        // busy spans grant+1 .. ack cycle, so a req held through ack is ignored
        cpu_busy_d = cpu_busy_q;
        if (cpu_grant) begin
            cpu_busy_d = 1'b1;
        end else if (pipe_cpu_ack) begin
            cpu_busy_d = 1'b0;
        end

        // run counts only video grants that actually made the CPU wait
        vid_run_d = vid_run_q;
        if (cpu_grant || !cpu_ok) begin
            vid_run_d = 4'd0;
        end else if (vid_grant && (vid_run_q < RUN_MAX)) begin
            vid_run_d = vid_run_q + 4'd1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_busy_q <= 1'b0;
            vid_run_q  <= 4'd0;
        end else begin
            cpu_busy_q <= cpu_busy_d;
            vid_run_q  <= vid_run_d;
        end
    end

    // RAM drive: the CPU address sits on the bus whenever video is not granted.
    assign ram_addr = vid_grant ? bus.vid_addr : bus.cpu_addr;
    assign ram_din  = bus.cpu_wdata;
    assign ram_we   = cpu_grant & bus.cpu_we & ~reset;

    zx_ram_resp_pipe u_resp_pipe (
        .clk         (clk),
        .reset       (reset),
        .owner_i     (owner),
        .ram_dout_i  (ram_dout),
        .cpu_ack_o   (pipe_cpu_ack),
        .cpu_rdata_o (bus.cpu_rdata),
        .vid_valid_o (pipe_vid_valid),
        .vid_data_o  (bus.vid_data)
    );

    // Responses already in the pipe are suppressed while reset is held.
    assign bus.cpu_ack   = pipe_cpu_ack & ~reset;
    assign bus.vid_valid = pipe_vid_valid & ~reset;
    assign bus.vid_gnt   = vid_grant & ~reset;

endmodule
